// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: fetch-state encoding and default reset constants shared by front-end blocks
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        REQ     = 2'd1,
        DELIVER = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: PC, redirect, instruction-memory and decode-side signals of the fetch unit
interface pc_fetch_unit_if;

    logic [31:0] pc_out;
    logic [31:0] pc_inc;
    logic        branch_en;
    logic [31:0] branch_target;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        stall;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] instr_in;
    logic [31:0] instr_out;
    logic        instr_valid;

    modport master (
        output pc_out, imem_req, instr_out, instr_valid,
        input  pc_inc, branch_en, branch_target, jump_en, jump_target,
               stall, imem_ack, instr_in
    );

    modport slave (
        input  pc_out, imem_req, instr_out, instr_valid,
        output pc_inc, branch_en, branch_target, jump_en, jump_target,
               stall, imem_ack, instr_in
    );

endinterface

// File: rtl/pc_fetch_unit_pc_next_mux.sv
// pc_next_mux: priority select of next PC, jump over branch over sequential
module pc_next_mux (
    input  logic        jump_en_i,
    input  logic [31:0] jump_target_i,
    input  logic        branch_en_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] pc_inc_i,
    output logic        redirect_o,
    output logic [31:0] next_pc_o
);

    // jump wins when both redirects arrive together
    always_comb begin
        redirect_o = jump_en_i | branch_en_i;
        next_pc_o  = jump_en_i ? jump_target_i : branch_en_i ? branch_target_i : pc_inc_i;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and req/ack instruction-fetch sequencer
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_fetch_unit_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic         kill_q, kill_d;
    logic [31:0]  redir_q, redir_d;
    logic         redirect;
    logic [31:0]  next_pc;

    pc_next_mux u_next_mux (
        .jump_en_i       (bus.jump_en),
        .jump_target_i   (bus.jump_target),
        .branch_en_i     (bus.branch_en),
        .branch_target_i (bus.branch_target),
        .pc_inc_i        (bus.pc_inc),
        .redirect_o      (redirect),
        .next_pc_o       (next_pc)
    );

    // state and datapath registers; a pending kill/redirect is dropped on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            kill_q  <= 1'b0;
            redir_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            kill_q  <= kill_d;
            redir_q <= redir_d;
        end
    end

    // next state: pc only moves outside an outstanding request, so the fetch address stays stable
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        kill_d  = kill_q;
        redir_d = redir_q;
        case (state_q)
            BOOT: begin
                state_d = REQ;
                if (redirect) pc_d = next_pc;
            end
            REQ: begin
                if (bus.imem_ack) begin
                    if (kill_q || redirect) begin
                        pc_d   = redirect ? next_pc : redir_q;
                        kill_d = 1'b0;
                    end else begin
                        instr_d = bus.instr_in;
                        valid_d = 1'b1;
                        state_d = DELIVER;
                    end
                end else if (redirect) begin
                    redir_d = next_pc;
                    kill_d  = 1'b1;
                end
            end
            DELIVER: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    pc_d    = next_pc;
                    state_d = REQ;
                end else if (!bus.stall) begin
                    valid_d = 1'b0;
                    pc_d    = next_pc;
                    state_d = REQ;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // Moore outputs: request only while in REQ
    always_comb begin
        bus.imem_req    = state_q == REQ;
        bus.pc_out      = pc_q;
        bus.instr_out   = instr_q;
        bus.instr_valid = valid_q;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenario checks of the fetch sequencer
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [65:0] exp;

    pc_fetch_unit_if bus ();

    pc_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.pc_inc = bus.pc_out + 32'd1;

    wire [65:0] obs = {bus.imem_req, bus.instr_valid, bus.pc_out, bus.instr_out};

    function automatic logic [31:0] w(input logic [31:0] a);
        return {8'hE0, a[23:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.branch_en = 0; bus.branch_target = 0; bus.jump_en = 0; bus.jump_target = 0;
        bus.stall = 0; bus.imem_ack = 0; bus.instr_in = 0;
        #1;
        checks++; exp = {1'b0, 1'b0, 32'h0, 32'h0};
        if (obs !== exp) begin errors++; $display("FAIL reset got=%h exp=%h", obs, exp); end
        repeat (2) tick();
        rst_n = 1'b1;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL boot got=%h exp=%h", obs, exp); end
        tick();
        checks++; exp = {1'b1, 1'b0, 32'h0, 32'h0};
        if (obs !== exp) begin errors++; $display("FAIL first_req got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            bus.imem_ack = 1; bus.instr_in = w(i);
            tick();
            bus.imem_ack = 0;
            checks++; exp = {1'b0, 1'b1, 32'(i), w(i)};
            if (obs !== exp) begin errors++; $display("FAIL seq_deliver%0d got=%h exp=%h", i, obs, exp); end
            tick();
            checks++; exp = {1'b1, 1'b0, 32'(i + 1), w(i)};
            if (obs !== exp) begin errors++; $display("FAIL seq_req%0d got=%h exp=%h", i, obs, exp); end
        end
    endtask

    task automatic test_stall();
        bus.imem_ack = 1; bus.instr_in = w(4);
        tick();
        bus.imem_ack = 0;
        tick();
        checks++; exp = {1'b1, 1'b0, 32'h5, w(4)};
        if (obs !== exp) begin errors++; $display("FAIL stall_pre got=%h exp=%h", obs, exp); end
        bus.imem_ack = 1; bus.instr_in = w(5); bus.stall = 1;
        tick();
        bus.imem_ack = 1; bus.instr_in = 32'hBAD0_BAD0;
        exp = {1'b0, 1'b1, 32'h5, w(5)};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL stall_hold%0d got=%h exp=%h", i, obs, exp); end
            tick();
        end
        bus.imem_ack = 0;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stall_last got=%h exp=%h", obs, exp); end
        bus.stall = 0;
        tick();
        checks++; exp = {1'b1, 1'b0, 32'h6, w(5)};
        if (obs !== exp) begin errors++; $display("FAIL stall_release got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_branch();
        bus.imem_ack = 1; bus.instr_in = w(6); bus.stall = 1;
        tick();
        bus.imem_ack = 0;
        checks++; exp = {1'b0, 1'b1, 32'h6, w(6)};
        if (obs !== exp) begin errors++; $display("FAIL br_deliver got=%h exp=%h", obs, exp); end
        bus.branch_en = 1; bus.branch_target = 32'h40;
        tick();
        bus.branch_en = 0; bus.stall = 0;
        checks++; exp = {1'b1, 1'b0, 32'h40, 32'h0};
        if (obs !== exp) begin errors++; $display("FAIL br_redirect got=%h exp=%h", obs, exp); end
        bus.imem_ack = 1; bus.instr_in = w(32'h40);
        tick();
        bus.imem_ack = 0;
        checks++; exp = {1'b0, 1'b1, 32'h40, w(32'h40)};
        if (obs !== exp) begin errors++; $display("FAIL br_fetch got=%h exp=%h", obs, exp); end
        tick();
        checks++; exp = {1'b1, 1'b0, 32'h41, w(32'h40)};
        if (obs !== exp) begin errors++; $display("FAIL br_next got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_jump_in_req();
        bus.jump_en = 1; bus.jump_target = 32'h100;
        tick();
        bus.jump_en = 0;
        exp = {1'b1, 1'b0, 32'h41, w(32'h40)};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL jmp_hold%0d got=%h exp=%h", i, obs, exp); end
            if (i < 2) tick();
        end
        bus.imem_ack = 1; bus.instr_in = 32'hDEAD_BEEF;
        tick();
        checks++; exp = {1'b1, 1'b0, 32'h100, w(32'h40)};
        if (obs !== exp) begin errors++; $display("FAIL jmp_kill got=%h exp=%h", obs, exp); end
        bus.instr_in = w(32'h100);
        tick();
        bus.imem_ack = 0;
        checks++; exp = {1'b0, 1'b1, 32'h100, w(32'h100)};
        if (obs !== exp) begin errors++; $display("FAIL jmp_refetch got=%h exp=%h", obs, exp); end
        tick();
    endtask

    task automatic test_priority();
        bus.imem_ack = 1; bus.instr_in = w(32'h101);
        tick();
        bus.imem_ack = 0;
        bus.jump_en = 1; bus.jump_target = 32'h200; bus.branch_en = 1; bus.branch_target = 32'h300;
        tick();
        bus.jump_en = 0; bus.branch_en = 0;
        checks++; exp = {1'b1, 1'b0, 32'h200, 32'h0};
        if (obs !== exp) begin errors++; $display("FAIL prio got=%h exp=%h", obs, exp); end
        bus.branch_en = 1; bus.branch_target = 32'h300;
        tick();
        bus.branch_en = 0; bus.jump_en = 1; bus.jump_target = 32'h400;
        tick();
        bus.jump_en = 0;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL redir_pending got=%h exp=%h", obs, exp); end
        bus.imem_ack = 1; bus.instr_in = w(32'h200);
        tick();
        checks++; exp = {1'b1, 1'b0, 32'h400, 32'h0};
        if (obs !== exp) begin errors++; $display("FAIL redir_overwrite got=%h exp=%h", obs, exp); end
        bus.instr_in = w(32'h400);
        tick();
        bus.imem_ack = 0;
        checks++; exp = {1'b0, 1'b1, 32'h400, w(32'h400)};
        if (obs !== exp) begin errors++; $display("FAIL redir_fetch got=%h exp=%h", obs, exp); end
        tick();
    endtask

    task automatic test_wrap();
        bus.imem_ack = 1; bus.instr_in = w(32'h401);
        tick();
        bus.imem_ack = 0;
        bus.jump_en = 1; bus.jump_target = 32'hFFFF_FFFF;
        tick();
        bus.jump_en = 0;
        checks++; exp = {1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0};
        if (obs !== exp) begin errors++; $display("FAIL wrap_pre got=%h exp=%h", obs, exp); end
        bus.imem_ack = 1; bus.instr_in = w(32'hFFFF_FFFF);
        tick();
        bus.imem_ack = 0;
        tick();
        checks++; exp = {1'b1, 1'b0, 32'h0, w(32'hFFFF_FFFF)};
        if (obs !== exp) begin errors++; $display("FAIL wrap got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_async_reset();
        bus.imem_ack = 1; bus.instr_in = w(0);
        tick();
        bus.imem_ack = 0;
        tick();
        bus.branch_en = 1; bus.branch_target = 32'h50;
        tick();
        bus.branch_en = 0;
        checks++; exp = {1'b1, 1'b0, 32'h1, w(0)};
        if (obs !== exp) begin errors++; $display("FAIL arst_pre got=%h exp=%h", obs, exp); end
        #2 rst_n = 1'b0;
        #1;
        checks++; exp = {1'b0, 1'b0, 32'h0, 32'h0};
        if (obs !== exp) begin errors++; $display("FAIL arst_async got=%h exp=%h", obs, exp); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; exp = {1'b1, 1'b0, 32'h0, 32'h0};
        if (obs !== exp) begin errors++; $display("FAIL arst_req got=%h exp=%h", obs, exp); end
        bus.imem_ack = 1; bus.instr_in = w(0);
        tick();
        bus.imem_ack = 0;
        checks++; exp = {1'b0, 1'b1, 32'h0, w(0)};
        if (obs !== exp) begin errors++; $display("FAIL arst_kill_lost got=%h exp=%h", obs, exp); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump_in_req();
        test_priority();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter register and instruction-fetch sequencer. It sits directly upstream of the 32-bit PC incrementer and drives that block's input with the current PC. It consumes the incremented PC, selects the next PC from sequential, branch or jump sources, and runs a req/ack handshake with instruction memory. PCs are word addresses (+1 per instruction).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, value of instr_out when no valid instruction is held.

Ports:
clk  in  1  single system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
pc_out  out  32  current PC; feeds the incrementer and the instruction-memory address.
pc_inc  in  32  incrementer result (pc_out + 1).
branch_en  in  1  taken-branch redirect request.
branch_target  in  32  branch destination PC.
jump_en  in  1  jump redirect request.
jump_target  in  32  jump destination PC.
stall  in  1  downstream cannot accept the held instruction.
imem_req  out  1  fetch request at address pc_out.
imem_ack  in  1  memory response valid; instr_in is valid this cycle.
instr_in  in  32  instruction word from memory.
instr_out  out  32  fetched instruction to the decode stage.
instr_valid  out  1  instr_out holds a live instruction.

Behaviour:
- Reset (async assert, sync-released use): pc_out=RESET_PC, instr_out=NOP_INSTR, instr_valid=0, imem_req=0, kill=0, redir_pc=0, state=BOOT.
- Redirect: redirect = jump_en | branch_en. Target = jump_target if jump_en, else branch_target. Jump wins on simultaneous assertion.
- States:
  - BOOT: imem_req=0 for one cycle after reset release, then go to REQ. A redirect in BOOT loads pc_out with the target and goes to REQ.
  - REQ: imem_req=1 (Moore output). pc_out is stable for the whole time imem_req is high.
    - Redirect without ack: redir_pc<=target, kill<=1, pc_out unchanged. A later redirect overwrites redir_pc.
    - imem_ack with kill=1 or redirect in the same cycle: discard instr_in. pc_out<=(same-cycle redirect ? target : redir_pc), kill<=0, stay in REQ. The new address is presented on the next cycle.
    - imem_ack, no kill, no redirect: instr_out<=instr_in, instr_valid<=1, go to DELIVER.
  - DELIVER: imem_req=0, instr_valid=1.
    - Redirect (takes priority over stall): instr_valid<=0, instr_out<=NOP_INSTR, pc_out<=target, go to REQ.
    - Else if !stall: instr_valid<=0, pc_out<=pc_inc, go to REQ.
    - Else (stall): hold all outputs unchanged.
- imem_ack outside REQ is ignored.
- Latency: with a 1-cycle ack (ack in first REQ cycle), throughput is one instruction per 2 cycles. Instruction becomes valid the cycle after ack.
- Arithmetic: no adder inside the block; pc_inc is trusted. Wrap 32'hFFFF_FFFF -> 32'h0000_0000 is accepted with no special handling.
- Reset mid-REQ: imem_req drops immediately (async), and the pending kill/redirect is lost.

Decomposition:
- Shared package: state encoding (BOOT, REQ, DELIVER as a 2-bit enum) and the RESET_PC and NOP_INSTR constants, reused by the decode and hazard blocks.
- One natural sub-module: pc_next_mux (combinational jump/branch/sequential priority select).
- The incrementer stays external and instantiated at the top level.

Test Plan:
1. Reset release, ack returned 1 cycle after each req, stall=0, pc_inc=pc_out+1 -> pc_out steps 0,1,2,3; instr_out equals the memory word at each address with instr_valid pulsing one cycle each; imem_req never high in BOOT.
2. Hold DELIVER at PC=5 with stall=1 for 4 cycles -> instr_out, instr_valid=1 and pc_out=5 stable; on release pc_out=6 and imem_req=1 next cycle.
3. branch_en with branch_target=0x40 in DELIVER while stall=1 -> instr_valid drops, pc_out=0x40, next fetch uses 0x40.
4. jump_en with jump_target=0x100 in REQ, ack 3 cycles later with 0xDEADBEEF -> 0xDEADBEEF is never valid; pc_out=0x100 after ack; refetch returns the word at 0x100.
5. jump_en (0x200) and branch_en (0x300) in the same DELIVER cycle -> pc_out=0x200.
6. pc_out=0xFFFFFFFF with pc_inc=0 -> next pc_out=0. Separately, assert rst_n=0 mid-REQ -> imem_req=0 and pc_out=RESET_PC without waiting for a clock edge.
